// File: rtl/mem_arb.sv
// Arbitrates the external memory bus between I-cache refills and D-cache refills/writebacks,
// splitting each cache line into bus beats. Define MEM_ARB_FIXED_PRIO_EN for fixed D > I priority.
module mem_arb #(
    parameter int LINE_W = 1024,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_data,
    output logic              d_dv,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BEAT_W-1:0] m_wdata,
    input  logic [BEAT_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int BEAT_AW = $clog2(BEATS);
    localparam int BOFF_W  = $clog2(BEAT_W / 8);
    localparam int OFF_W   = BEAT_AW + BOFF_W;
    localparam int LA_W    = ADDR_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [BEAT_AW-1:0]  beat_q, beat_d;
    logic [LA_W-1:0]     line_q, line_d;
    logic                own_d_q, own_d_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]   i_data_q, i_data_d;
    logic [LINE_W-1:0]   d_data_q, d_data_d;

    logic want_i, want_d, gnt_dside;

    assign want_i = i_rd;
    assign want_d = d_rd | d_wr;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign gnt_dside = want_d;
`else
    logic last_d_q;

    // last_d_q resets to "I granted last" so the first contended grant goes to D
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_d_q <= 1'b0;
        end else if (state_q == S_IDLE && (want_i || want_d)) begin
            last_d_q <= gnt_dside;
        end
    end

    assign gnt_dside = want_d & (~want_i | ~last_d_q);
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            line_q   <= '0;
            own_d_q  <= 1'b0;
            buf_q    <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            own_d_q  <= own_d_d;
            buf_q    <= buf_d;
            i_data_q <= i_data_d;
            d_data_q <= d_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        line_d   = line_q;
        own_d_d  = own_d_q;
        buf_d    = buf_q;
        i_data_d = i_data_q;
        d_data_d = d_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (want_i || want_d) begin
                    line_d  = gnt_dside ? d_addr[ADDR_W-1:OFF_W] : i_addr[ADDR_W-1:OFF_W];
                    own_d_d = gnt_dside;
                    beat_d  = '0;
                    if (gnt_dside && d_wr) begin
                        state_d = S_WR;
                        buf_d   = d_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD, S_WR: begin
                if (m_ack) begin
                    if (state_q == S_RD) begin
                        buf_d[int'(beat_q)*BEAT_W +: BEAT_W] = m_rdata;
                    end
                    beat_d = beat_q + 1'b1;
                    // The final beat is folded into the owner's output so it is valid alongside dv
                    if (beat_q == BEAT_AW'(BEATS - 1)) begin
                        state_d = S_DONE;
                        if (state_q == S_RD) begin
                            if (own_d_q) begin
                                d_data_d = buf_d;
                            end else begin
                                i_data_d = buf_d;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m_req   = (state_q == S_RD) || (state_q == S_WR);
    assign m_we    = (state_q == S_WR);
    assign m_addr  = {line_q, beat_q, {BOFF_W{1'b0}}};
    assign m_wdata = buf_q[int'(beat_q)*BEAT_W +: BEAT_W];
    assign i_dv    = (state_q == S_DONE) && !own_d_q;
    assign d_dv    = (state_q == S_DONE) && own_d_q;
    assign i_data  = i_data_q;
    assign d_data  = d_data_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized and directed bench for mem_arb against a transaction-level model of line operations.
module tb_mem_arb;

    logic           clk = 1'b0;
    logic           clr_n;
    logic           i_rd;
    logic [63:0]    i_addr;
    logic [1023:0]  i_data;
    logic           i_dv;
    logic           d_rd;
    logic           d_wr;
    logic [63:0]    d_addr;
    logic [1023:0]  d_wdata;
    logic [1023:0]  d_data;
    logic           d_dv;
    logic           m_req;
    logic           m_we;
    logic [63:0]    m_addr;
    logic [63:0]    m_wdata;
    logic [63:0]    m_rdata;
    logic           m_ack;

    int total = 0;
    int bad   = 0;
    bit idx_mode = 1'b0;

    always #5 clk = ~clk;

    mem_arb #(.LINE_W(1024), .BEAT_W(64), .ADDR_W(64)) dut (
        .clk(clk), .clr_n(clr_n),
        .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_dv(i_dv),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_data(d_data), .d_dv(d_dv),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    function automatic logic [63:0] memf(logic [63:0] a);
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] beat_val(logic [63:0] a);
        return idx_mode ? {60'd0, a[6:3]} : memf(a);
    endfunction

    // Memory responder: read data is a pure function of the beat address
    assign m_rdata = beat_val(m_addr);

    // ---------------- transaction-level model ----------------
    bit            mb_busy, mb_done, mb_own_d, mb_wr, mb_last_d;
    logic [56:0]   mb_line;
    int unsigned   mb_cnt;
    logic [63:0]   mb_rbuf [16];
    logic [1023:0] mb_wline, exp_i, exp_d;
    bit            gq[$];

    typedef struct {logic [63:0] a; logic [63:0] w; logic we;} beat_t;
    beat_t blog[$];
    bit    dvlog[$];
    bit    snap_req;
    beat_t snap;

    task automatic model_reset();
        mb_busy = 0; mb_done = 0; mb_own_d = 0; mb_wr = 0; mb_last_d = 0;
        mb_line = '0; mb_cnt = 0; exp_i = '0; exp_d = '0; mb_wline = '0;
        snap_req = 0;
    endtask

    function automatic logic [63:0] model_addr();
        logic [3:0] b;
        b = mb_cnt[3:0];
        return {mb_line, b, 3'b000};
    endfunction

    task automatic model_step();
        logic [1023:0] line;
        bit gd;
        if (!clr_n) begin
            model_reset();
            return;
        end
        if (snap_req && m_ack) blog.push_back(snap);
        if (mb_done) begin
            mb_done = 0;
        end else if (mb_busy) begin
            if (m_ack) begin
                if (!mb_wr) mb_rbuf[mb_cnt] = beat_val(model_addr());
                mb_cnt++;
                if (mb_cnt == 16) begin
                    mb_busy = 0;
                    mb_done = 1;
                    if (!mb_wr) begin
                        for (int unsigned k = 0; k < 16; k++) line[k*64 +: 64] = mb_rbuf[k];
                        if (mb_own_d) exp_d = line; else exp_i = line;
                    end
                end
            end
        end else if (i_rd || d_rd || d_wr) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            gd = d_rd || d_wr;
`else
            gd = (d_rd || d_wr) && (!i_rd || !mb_last_d);
`endif
            mb_busy   = 1;
            mb_own_d  = gd;
            mb_wr     = gd && d_wr;
            mb_line   = gd ? d_addr[63:7] : i_addr[63:7];
            mb_cnt    = 0;
            mb_wline  = d_wdata;
            mb_last_d = gd;
            gq.push_back(gd);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk64(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_line(string nm, logic [1023:0] act, logic [1023:0] exp);
        total++;
        for (int unsigned k = 0; k < 16; k++) begin
            if (act[k*64 +: 64] !== exp[k*64 +: 64]) begin
                bad++;
                $display("FAIL %s beat %0d: got %0h want %0h @%0t", nm, k, act[k*64 +: 64], exp[k*64 +: 64], $time);
                break;
            end
        end
    endtask

    task automatic compare_all();
        chk64("m_req", {63'd0, m_req}, {63'd0, mb_busy});
        chk64("m_we", {63'd0, m_we}, {63'd0, mb_busy && mb_wr});
        if (mb_busy) chk64("m_addr", m_addr, model_addr());
        if (mb_busy && mb_wr) chk64("m_wdata", m_wdata, mb_wline[mb_cnt*64 +: 64]);
        chk64("i_dv", {63'd0, i_dv}, {63'd0, mb_done && !mb_own_d});
        chk64("d_dv", {63'd0, d_dv}, {63'd0, mb_done && mb_own_d});
        chk_line("i_data", i_data, exp_i);
        chk_line("d_data", d_data, exp_d);
        if (i_dv) dvlog.push_back(1'b0);
        if (d_dv) dvlog.push_back(1'b1);
        snap_req = m_req;
        snap.a   = m_addr;
        snap.w   = m_wdata;
        snap.we  = m_we;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until_dv(string nm, input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (i_dv || d_dv) return;
        end
        total++;
        bad++;
        $display("FAIL %s: timeout, got no dv want dv within %0d cycles", nm, lim);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        model_reset();
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    initial begin
        logic [1023:0] expl;
        int            errs;
        clr_n = 1'b0; i_rd = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0;
        d_wdata = '0; m_ack = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // reset state
        chk64("rst_m_req", {63'd0, m_req}, 64'd0);
        chk64("rst_m_addr", m_addr, 64'd0);
        chk64("rst_dv", {62'd0, i_dv, d_dv}, 64'd0);
        chk_line("rst_i_data", i_data, '0);

        // I-only refill with beat-index read data
        idx_mode = 1; i_rd = 1; i_addr = 64'h1234; m_ack = 1; blog.delete();
        run_until_dv("i_only_dv", 40);
        i_rd = 0;
        errs = 0;
        for (int unsigned k = 0; k < 16; k++)
            if (k >= blog.size() || blog[k].a != 64'h1200 + 8*k || blog[k].we) errs++;
        chk64("i_only_beats", 64'(errs) + 64'(blog.size() != 16), 64'd0);
        for (int unsigned k = 0; k < 16; k++) expl[k*64 +: 64] = 64'(k);
        chk_line("i_only_line", i_data, expl);
        chk64("i_only_dv", {63'd0, i_dv}, 64'd1);
        tick();
        chk64("i_only_dv_pulse", {63'd0, i_dv}, 64'd0);

        // D writeback
        d_wr = 1; d_addr = 64'h8000; blog.delete();
        for (int unsigned k = 0; k < 16; k++) d_wdata[k*64 +: 64] = 64'hA0 + 64'(k);
        run_until_dv("wb_dv", 40);
        chk64("wb_d_dv", {63'd0, d_dv}, 64'd1);
        d_wr = 0; d_wdata = '1;
        errs = 0;
        for (int unsigned k = 0; k < 16; k++)
            if (k >= blog.size() || blog[k].a != 64'h8000 + 8*k || !blog[k].we ||
                blog[k].w != 64'hA0 + 64'(k)) errs++;
        chk64("wb_beats", 64'(errs) + 64'(blog.size() != 16), 64'd0);
        chk_line("wb_d_data_unchanged", d_data, '0);

        // contention from reset
        idx_mode = 0;
        do_reset();
        i_rd = 1; d_rd = 1; i_addr = 64'h3_0000; d_addr = 64'h5_0000; m_ack = 1;
        dvlog.delete(); gq.delete();
        for (int i = 0; i < 200 && dvlog.size() < 4; i++) tick();
        i_rd = 0; d_rd = 0;
        if (dvlog.size() < 4) begin
            total++; bad++;
            $display("FAIL contention: got %0d dv pulses want 4", dvlog.size());
        end else begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk64("contention_order", {60'd0, dvlog[0], dvlog[1], dvlog[2], dvlog[3]}, 64'b1111);
`else
            chk64("contention_order", {60'd0, dvlog[0], dvlog[1], dvlog[2], dvlog[3]}, 64'b1010);
            chk64("model_grant_order", {60'd0, gq[0], gq[1], gq[2], gq[3]}, 64'b1010);
`endif
        end
        tick(); tick();

        // wait states: one ack every fourth cycle
        i_rd = 1; i_addr = 64'h7_7700; blog.delete();
        for (int i = 0; i < 200; i++) begin
            m_ack = ((i % 4) == 3);
            tick();
            if (i_dv) break;
        end
        chk64("wait_dv", {63'd0, i_dv}, 64'd1);
        chk64("wait_acks", 64'(blog.size()), 64'd16);
        i_rd = 0; m_ack = 1;
        tick(); tick();

        // reset in the middle of a transfer
        i_rd = 1; i_addr = 64'h4000; blog.delete();
        for (int i = 0; i < 40 && blog.size() < 7; i++) tick();
        clr_n = 1'b0;
        #1;
        chk64("abort_m_req", {63'd0, m_req}, 64'd0);
        chk64("abort_m_addr", m_addr, 64'd0);
        model_reset();
        tick(); tick();
        clr_n = 1'b1; blog.delete();
        run_until_dv("restart_dv", 40);
        i_rd = 0;
        chk64("restart_beat0", blog.size() > 0 ? blog[0].a : 64'hFFFF, 64'h4000);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) i_rd = 1'($urandom);
            if ($urandom_range(7) == 0) d_rd = 1'($urandom);
            if ($urandom_range(9) == 0) d_wr = 1'($urandom);
            if ((i_dv || d_dv) && $urandom_range(1) == 0) begin
                i_rd = 0; d_rd = 0; d_wr = 0;
            end
            i_addr = {$urandom, $urandom};
            d_addr = {$urandom, $urandom};
            for (int unsigned k = 0; k < 32; k++) d_wdata[k*32 +: 32] = $urandom;
            m_ack = ($urandom_range(3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
